// File: rtl/register_rr_arbiter.sv
// register_rr_arbiter: round-robin arbiter that lets NUM_REQ agents share one
// WIDTH-bit register. The grant is combinational. The winner's data, its index
// and a "written since reset" flag are registered on the next rising edge.
module register_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   data,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [WIDTH-1:0]           out,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       valid
);

  localparam int IW = $clog2(NUM_REQ);

  logic [IW-1:0] ptr;
  logic [IW-1:0] win;
  logic          any_gnt;

  // Priority after a grant to w: w+1, wrapping explicitly because NUM_REQ
  // need not be a power of two.
  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] w);
    if (int'(w) == NUM_REQ - 1) next_ptr = '0;
    else                        next_ptr = w + 1'b1;
  endfunction

  // Scan from ptr upward with wrap-around; the first active requester wins.
  // Reset masks every grant so that no write can happen during reset.
  always_comb begin
    int  idx;
    logic found;
    gnt   = '0;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        win      = IW'(idx);
      end
    end
    if (rst) begin
      gnt = '0;
      win = '0;
    end
  end

  assign any_gnt = |gnt;

  // Register stage: capture the winner's data and index, then advance the
  // pointer. With no grant, all state holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      out   <= '0;
      owner <= '0;
      valid <= 1'b0;
      ptr   <= '0;
    end else if (any_gnt) begin
      out   <= data[win*WIDTH +: WIDTH];
      owner <= win;
      valid <= 1'b1;
      ptr   <= next_ptr(win);
    end
  end

endmodule

// File: tb/tb_register_rr_arbiter.sv
// Testbench for register_rr_arbiter: directed scenarios followed by random
// traffic, all compared against a behavioural round-robin model.
module tb_register_rr_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = $clog2(N);

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic [N*W-1:0]   data;
  logic [N-1:0]     gnt;
  logic [W-1:0]     out;
  logic [IW-1:0]    owner;
  logic             valid;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int          m_ptr   = 0;
  int          m_owner = 0;
  logic [W-1:0] m_out  = '0;
  logic        m_valid = 1'b0;

  register_rr_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .data (data),
    .gnt  (gnt),
    .out  (out),
    .owner(owner),
    .valid(valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Winner of one arbitration round: scan the priority order starting at
  // the model pointer. Returns -1 when nobody is asking.
  function automatic int model_winner(input int p, input logic [N-1:0] q);
    for (int k = 0; k < N; k++) begin
      if (q[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // One clock cycle: apply inputs, check the combinational grant, clock,
  // advance the model, then check the registered outputs.
  task automatic cycle(input logic r, input logic [N-1:0] q, input logic [N*W-1:0] d);
    int w;
    logic [N-1:0] exp_gnt;
    rst  = r;
    req  = q;
    data = d;
    #1;
    w = r ? -1 : model_winner(m_ptr, q);
    exp_gnt = (w < 0) ? '0 : (N'(1) << w);
    check("gnt", 32'(gnt), 32'(exp_gnt));
    check("gnt_onehot0", 32'($countones(gnt) <= 1), 32'd1);
    @(posedge clk);
    if (r) begin
      m_out = '0; m_owner = 0; m_valid = 1'b0; m_ptr = 0;
    end else if (w >= 0) begin
      m_out   = d[w*W +: W];
      m_owner = w;
      m_valid = 1'b1;
      m_ptr   = (w + 1) % N;
    end
    #1;
    check("out",   32'(out),   32'(m_out));
    check("owner", 32'(owner), 32'(m_owner));
    check("valid", 32'(valid), 32'(m_valid));
  endtask

  initial begin
    logic [N*W-1:0] d;
    int guard;

    // Reset with every requester asking and all data ones
    rst = 1'b1; req = '0; data = '0;
    cycle(1'b1, 4'hF, '1);
    cycle(1'b1, 4'hF, '1);
    check("rst_out", 32'(out), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    cycle(1'b0, 4'hF, '1);
    check("first_owner", 32'(owner), 32'd0);
    check("first_out", 32'(out), 32'hFF);

    // All four continuously asking, rotating grants
    d = 32'h13121110;
    for (int i = 0; i < 6; i++) cycle(1'b0, 4'hF, d);

    // Lone requester 2 with incrementing data
    for (int i = 0; i < 5; i++) begin
      d = '0;
      d[2*W +: W] = 8'h20 + 8'(i);
      cycle(1'b0, 4'b0100, d);
      check("lone_owner", 32'(owner), 32'd2);
    end

    // Wrap-around: requester 3 wins, then 0, then 3 again
    d = 32'hA3B2C1D0;
    cycle(1'b0, 4'b1000, d);
    cycle(1'b0, 4'b1001, d);
    check("wrap_owner0", 32'(owner), 32'd0);
    cycle(1'b0, 4'b1001, d);
    check("wrap_owner3", 32'(owner), 32'd3);

    // Idle hold after a write of 5A by requester 1
    d = 32'h00005A00;
    cycle(1'b0, 4'b0010, d);
    for (int i = 0; i < 10; i++) cycle(1'b0, 4'b0000, 32'hDEADBEEF);
    check("idle_out", 32'(out), 32'h5A);
    cycle(1'b0, 4'hF, 32'h44332211);
    check("idle_next_owner", 32'(owner), 32'd2);

    // Reset mid-operation while the pointer sits at 2
    guard = 0;
    while (m_ptr != 2 && guard < 2*N) begin
      cycle(1'b0, 4'hF, 32'h87654321);
      guard++;
    end
    check("mid_ptr_reached", 32'(m_ptr), 32'd2);
    cycle(1'b1, 4'hF, 32'h87654321);
    cycle(1'b0, 4'hF, 32'h87654321);
    check("post_rst_owner", 32'(owner), 32'd0);

    // Random traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 49) == 0), N'($urandom), N*W'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
